// File: rtl/branch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_sequencer: execute/commit sub-FSM for branch and jump instructions   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module branch_sequencer #(
  parameter logic [2:0] ALU_SUB      = 3'b010,
  parameter logic [1:0] PCSRC_ALUOUT = 2'b01,
  parameter logic [1:0] PCSRC_JUMP   = 2'b10,
  parameter int         CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       opcode,
  input  logic             alu_gt,
  input  logic             alu_eq,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [1:0]       branch_ctrl,
  output logic             pc_write_cond,
  output logic             pc_write,
  output logic [1:0]       pc_source,
  output logic             reg_write,
  output logic             link_sel,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BR_EXEC = 3'd1,
    S_J_LINK  = 3'd2,
    S_J_EXEC  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t     r_state;
  state_t     w_state_n;
  logic [1:0] w_br_ctrl_n;
  logic       w_illegal_n;
  logic       w_taken;

  always_comb begin
    w_state_n   = r_state;
    w_br_ctrl_n = branch_ctrl;
    w_illegal_n = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          case (opcode)
            6'h02: w_state_n = S_J_EXEC;
            6'h03: w_state_n = S_J_LINK;
            6'h04: begin w_state_n = S_BR_EXEC; w_br_ctrl_n = 2'b11; end
            6'h05: begin w_state_n = S_BR_EXEC; w_br_ctrl_n = 2'b10; end
            6'h06: begin w_state_n = S_BR_EXEC; w_br_ctrl_n = 2'b01; end
            6'h07: begin w_state_n = S_BR_EXEC; w_br_ctrl_n = 2'b00; end
            default: w_illegal_n = 1'b1;
          endcase
        end
      end
      S_BR_EXEC: w_state_n = S_DONE;
      S_J_LINK:  w_state_n = S_J_EXEC;
      S_J_EXEC:  w_state_n = S_DONE;
      default:   w_state_n = S_IDLE;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (branch_ctrl)
      2'b00: w_taken = alu_gt;
      2'b01: w_taken = ~alu_gt;
      2'b10: w_taken = ~alu_eq;
      2'b11: w_taken = alu_eq;
      default: w_taken = 1'b0;
    endcase
  end

  // Outputs are registered from the next state so they mirror the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      illegal       <= 1'b0;
      alu_src_a     <= 1'b0;
      alu_src_b     <= 2'b00;
      alu_op        <= 3'b000;
      branch_ctrl   <= 2'b00;
      pc_write_cond <= 1'b0;
      pc_write      <= 1'b0;
      pc_source     <= 2'b00;
      reg_write     <= 1'b0;
      link_sel      <= 1'b0;
      br_count      <= '0;
      taken_count   <= '0;
    end else begin
      r_state       <= w_state_n;
      busy          <= (w_state_n == S_BR_EXEC) || (w_state_n == S_J_LINK) ||
                       (w_state_n == S_J_EXEC);
      done          <= (w_state_n == S_DONE);
      illegal       <= w_illegal_n;
      alu_src_a     <= (w_state_n == S_BR_EXEC);
      alu_src_b     <= 2'b00;
      alu_op        <= (w_state_n == S_BR_EXEC) ? ALU_SUB : 3'b000;
      branch_ctrl   <= w_br_ctrl_n;
      pc_write_cond <= (w_state_n == S_BR_EXEC);
      pc_write      <= (w_state_n == S_J_EXEC);
      pc_source     <= (w_state_n == S_BR_EXEC) ? PCSRC_ALUOUT :
                       (w_state_n == S_J_EXEC)  ? PCSRC_JUMP   : 2'b00;
      reg_write     <= (w_state_n == S_J_LINK);
      link_sel      <= (w_state_n == S_J_LINK);
      if (r_state == S_BR_EXEC) begin
        if (br_count != CNT_MAX)
          br_count <= br_count + CNT_ONE;
        if (w_taken && (taken_count != CNT_MAX))
          taken_count <= taken_count + CNT_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_branch_sequencer: directed self-checking bench for branch_sequencer      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_branch_sequencer;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset, start, alu_gt, alu_eq;
  logic [5:0]       opcode;
  logic             busy, done, illegal, alu_src_a;
  logic [1:0]       alu_src_b, branch_ctrl, pc_source;
  logic [2:0]       alu_op;
  logic             pc_write_cond, pc_write, reg_write, link_sel;
  logic [CNT_W-1:0] br_count, taken_count;

  int n_cmp = 0;
  int n_err = 0;

  branch_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .alu_gt(alu_gt), .alu_eq(alu_eq), .busy(busy), .done(done),
    .illegal(illegal), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .branch_ctrl(branch_ctrl), .pc_write_cond(pc_write_cond),
    .pc_write(pc_write), .pc_source(pc_source), .reg_write(reg_write),
    .link_sel(link_sel), .br_count(br_count), .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  // Inputs change at the falling edge; outputs are checked at the next falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [5:0] op);
    start  = 1'b1;
    opcode = op;
    tick();
    start  = 1'b0;
    opcode = 6'h00;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; opcode = 6'h00; alu_gt = 1'b0; alu_eq = 1'b0;
    @(negedge clk);
    tick();
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_outs", {4'd0, done, illegal, alu_src_a, alu_src_b, alu_op,
                       pc_write_cond, pc_write, reg_write, link_sel}, 16'd0);
    check("rst_sel", {12'd0, branch_ctrl, pc_source}, 16'd0);
    check("rst_cnt", {12'd0, br_count, taken_count}, 16'd0);
    reset = 1'b0;
    tick();

    // beq taken
    alu_eq = 1'b1;
    issue(6'h04);
    check("beq_c1_ctrl", {14'd0, branch_ctrl}, 16'h3);
    check("beq_c1_pwc", {15'd0, pc_write_cond}, 16'h1);
    check("beq_c1_psrc", {14'd0, pc_source}, 16'h1);
    check("beq_c1_alu", {10'd0, alu_src_a, alu_src_b, alu_op}, {10'd0, 1'b1, 2'b00, 3'b010});
    check("beq_c1_busy", {14'd0, busy, done}, 16'h2);
    check("beq_c1_pw", {14'd0, pc_write, reg_write}, 16'h0);
    tick();
    check("beq_c2_done", {14'd0, busy, done}, 16'h1);
    check("beq_c2_pwc", {15'd0, pc_write_cond}, 16'h0);
    check("beq_c2_taken", {14'd0, taken_count}, 16'h1);
    check("beq_c2_br", {14'd0, br_count}, 16'h1);
    tick();
    check("beq_c3_done", {15'd0, done}, 16'h0);

    // bgt not taken
    alu_eq = 1'b0; alu_gt = 1'b0;
    issue(6'h07);
    check("bgt_c1_ctrl", {14'd0, branch_ctrl}, 16'h0);
    check("bgt_c1_pwc", {15'd0, pc_write_cond}, 16'h1);
    tick();
    check("bgt_c2_br", {14'd0, br_count}, 16'h2);
    check("bgt_c2_taken", {14'd0, taken_count}, 16'h1);
    tick();

    // jal
    issue(6'h03);
    check("jal_c1_link", {13'd0, reg_write, link_sel, busy}, 16'h7);
    check("jal_c1_pc", {14'd0, pc_write, pc_write_cond}, 16'h0);
    tick();
    check("jal_c2_pw", {15'd0, pc_write}, 16'h1);
    check("jal_c2_psrc", {14'd0, pc_source}, 16'h2);
    check("jal_c2_busy", {13'd0, busy, reg_write, link_sel}, 16'h4);
    tick();
    check("jal_c3_done", {13'd0, done, busy, pc_write}, 16'h4);
    tick();

    // j
    issue(6'h02);
    check("j_c1_pw", {13'd0, pc_write, reg_write, busy}, 16'h5);
    tick();
    check("j_c2_done", {15'd0, done}, 16'h1);
    tick();

    // illegal opcode
    issue(6'h3F);
    check("ill_c1", {14'd0, illegal, busy}, 16'h2);
    tick();
    check("ill_c2", {13'd0, illegal, busy, done}, 16'h0);

    // start while in BR_EXEC is ignored (beq not taken)
    issue(6'h04);
    start = 1'b1; opcode = 6'h02;
    tick();
    start = 1'b0; opcode = 6'h00;
    check("ign_c2_done", {14'd0, done, pc_write}, 16'h2);
    tick();
    check("ign_c3_idle", {13'd0, busy, done, pc_write}, 16'h0);
    check("ign_cnt", {12'd0, br_count, taken_count}, 16'hD);

    // saturation: 5 taken bne with 2-bit counters
    reset = 1'b1; tick(); reset = 1'b0;
    alu_eq = 1'b0;
    for (int k = 0; k < 5; k++) begin
      issue(6'h05);
      if (k == 0) check("bne_ctrl", {14'd0, branch_ctrl}, 16'h2);
      tick();
      tick();
      if (k == 2) check("bne_taken3", {14'd0, taken_count}, 16'h3);
    end
    check("sat_taken", {14'd0, taken_count}, 16'h3);
    check("sat_br", {14'd0, br_count}, 16'h3);

    // ble taken (alu_gt=0) after counters cleared
    reset = 1'b1; tick(); reset = 1'b0;
    issue(6'h06);
    check("ble_ctrl", {14'd0, branch_ctrl}, 16'h1);
    tick();
    check("ble_taken", {14'd0, taken_count}, 16'h1);
    tick();

    // reset during J_LINK
    issue(6'h03);
    check("rjl_c1", {15'd0, reg_write}, 16'h1);
    reset = 1'b1;
    tick();
    check("rjl_idle", {12'd0, busy, done, pc_write, reg_write}, 16'h0);
    check("rjl_cnt", {12'd0, br_count, taken_count}, 16'h0);
    reset = 1'b0;
    tick();
    check("rjl_after", {13'd0, pc_write, done, busy}, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
